// File: rtl/count_pkg.sv
// Shared encodings for the count sequencer: FSM states and command opcodes.
package count_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE,
    ST_ABRT
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick every div+1 enabled cycles, held at zero while idle or loading.
module tick_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] presc;

  assign tick = en & (presc == div);

  // Wrap on compare rather than overflow, so div of all-ones is a legal period.
  always_ff @(posedge clk) begin
    if (rst || load || !en) begin
      presc <= '0;
    end else if (presc == div) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller for the downstream event counter: clears it, paces inc
// through the prescaler, and stops when the counter reports it has reached max_val.
module count_sequencer
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  input  logic             cnt_eq,
  output logic             clr,
  output logic             inc,
  output logic [WIDTH-1:0] max_val,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t           state;
  logic             run_mode;
  logic [DIV_W-1:0] div_reg;
  logic             tick;

  tick_prescaler #(
    .DIV_W(DIV_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_RUN),
    .load (state == ST_CLEAR),
    .div  (div_reg),
    .tick (tick)
  );

  // Only combinational output: must drop in the same cycle abort, rst or eq appear.
  assign inc       = tick & ~cnt_eq & ~abort & ~rst;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign clr       = (state == ST_CLEAR);
  assign done      = (state == ST_DONE);
  assign aborted   = (state == ST_ABRT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      run_mode <= 1'b0;
      max_val  <= '0;
      div_reg  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_RUN) begin
              max_val  <= cmd_limit;
              div_reg  <= cmd_div;
              run_mode <= 1'b1;
              state    <= ST_CLEAR;
            end else if (cmd_op == OP_CLEAR) begin
              run_mode <= 1'b0;
              state    <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (abort)         state <= ST_ABRT;
          else if (run_mode) state <= ST_RUN;
          else               state <= ST_IDLE;
        end
        ST_RUN: begin
          if (abort)       state <= ST_ABRT;
          else if (cnt_eq) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        ST_ABRT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
